// File: rtl/cruise_speed_controller_if.sv
// Driver-control / speed-sensor / throttle bundle for the cruise speed controller.
// The controller takes the slave side; the vehicle-side logic or a bench takes the master side.
interface cruise_speed_controller_if;
  logic       cruise_on;
  logic       set;
  logic       resume;
  logic       inc;
  logic       dec;
  logic       brake;
  logic [7:0] speed;
  logic       speed_valid;
  logic       throttle_up;
  logic       throttle_down;
  logic       cruise_active;
  logic [7:0] target_speed;

  modport master (
    output cruise_on, set, resume, inc, dec, brake, speed, speed_valid,
    input  throttle_up, throttle_down, cruise_active, target_speed
  );

  modport slave (
    input  cruise_on, set, resume, inc, dec, brake, speed, speed_valid,
    output throttle_up, throttle_down, cruise_active, target_speed
  );
endinterface

// File: rtl/cruise_speed_controller.sv
// Cruise-control sequencer: holds the target speed and drives throttle_up/throttle_down.
// Define CRUISE_HYST_EN to compare against a +/-DEADBAND window instead of the exact target.

module eight_bit_comparator (
  input  logic       en_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic       l_o,
  output logic       g_o,
  output logic       eq_o
);
  assign l_o  = en_i & (a_i <  b_i);
  assign g_o  = en_i & (a_i >  b_i);
  assign eq_o = en_i & (a_i == b_i);
endmodule

module cruise_speed_controller #(
  parameter logic [7:0] MIN_SPEED = 8'd45,
  parameter logic [7:0] MAX_SPEED = 8'd200,
  parameter logic [7:0] STEP      = 8'd2
`ifdef CRUISE_HYST_EN
  , parameter logic [7:0] DEADBAND = 8'd3
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  cruise_speed_controller_if.slave     ctl
);

  typedef enum logic [1:0] {S_OFF, S_READY, S_CRUISE, S_SUSPEND} state_e;

  state_e     state_q, state_d;
  logic [7:0] target_q, target_d;
  logic       up_q, up_d;
  logic       dn_q, dn_d;
  logic       active_q, active_d;

  logic       in_range;
  logic       set_ok;
  logic [8:0] inc_sum;
  logic [7:0] inc_val;
  logic [7:0] dec_val;
  logic       cmp_en;
  logic       cmp_up;
  logic       cmp_dn;

  assign in_range = (ctl.speed >= MIN_SPEED) && (ctl.speed <= MAX_SPEED);
  // set/resume are only honoured with the brake released
  assign set_ok   = ctl.set && in_range && !ctl.brake;

  assign inc_sum  = {1'b0, target_q} + {1'b0, STEP};
  assign inc_val  = (inc_sum > {1'b0, MAX_SPEED}) ? MAX_SPEED : inc_sum[7:0];
  assign dec_val  = ({1'b0, target_q} < ({1'b0, MIN_SPEED} + {1'b0, STEP})) ?
                    MIN_SPEED : (target_q - STEP);

  // Comparator sees the registered (old) target, so a same-cycle adjust is not visible yet
  assign cmp_en   = (state_q == S_CRUISE);

`ifdef CRUISE_HYST_EN
  logic [7:0] lo_lim, hi_lim;
  logic [8:0] hi_sum;
  logic       lo_l, lo_g, lo_eq, hi_l, hi_g, hi_eq;
  logic       inside;

  assign lo_lim = (target_q > DEADBAND) ? (target_q - DEADBAND) : 8'd0;
  assign hi_sum = {1'b0, target_q} + {1'b0, DEADBAND};
  assign hi_lim = hi_sum[8] ? 8'hFF : hi_sum[7:0];

  eight_bit_comparator u_cmp_lo (
    .en_i (cmp_en), .a_i (ctl.speed), .b_i (lo_lim),
    .l_o  (lo_l),   .g_o (lo_g),      .eq_o (lo_eq)
  );
  eight_bit_comparator u_cmp_hi (
    .en_i (cmp_en), .a_i (ctl.speed), .b_i (hi_lim),
    .l_o  (hi_l),   .g_o (hi_g),      .eq_o (hi_eq)
  );

  assign inside = (lo_g | lo_eq) & (hi_l | hi_eq);
  assign cmp_up = lo_l & ~inside;
  assign cmp_dn = hi_g & ~inside;
`else
  logic c_l, c_g, c_eq;

  eight_bit_comparator u_cmp (
    .en_i (cmp_en), .a_i (ctl.speed), .b_i (target_q),
    .l_o  (c_l),    .g_o (c_g),       .eq_o (c_eq)
  );

  assign cmp_up = c_l & ~c_eq;
  assign cmp_dn = c_g & ~c_eq;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_OFF;
      target_q <= 8'd0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      active_q <= active_d;
    end
  end

  // Next state and target
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (!ctl.cruise_on) begin
      state_d  = S_OFF;
      target_d = 8'd0;
    end else begin
      unique case (state_q)
        S_OFF: state_d = S_READY;
        S_READY: begin
          if (set_ok) begin
            state_d  = S_CRUISE;
            target_d = ctl.speed;
          end
        end
        S_CRUISE: begin
          if (ctl.brake) begin
            state_d = S_SUSPEND;
          end else if (set_ok) begin
            target_d = ctl.speed;
          end else if (!ctl.resume && (ctl.inc != ctl.dec)) begin
            target_d = ctl.inc ? inc_val : dec_val;
          end
        end
        S_SUSPEND: begin
          if (set_ok) begin
            state_d  = S_CRUISE;
            target_d = ctl.speed;
          end else if (ctl.resume && !ctl.brake && (target_q != 8'd0)) begin
            state_d = S_CRUISE;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // Outputs: throttles track the last sample seen in CRUISE and clear when leaving it
  always_comb begin
    active_d = (state_d == S_CRUISE);
    up_d     = up_q;
    dn_d     = dn_q;
    if (state_d != S_CRUISE) begin
      up_d = 1'b0;
      dn_d = 1'b0;
    end else if (cmp_en && ctl.speed_valid) begin
      up_d = cmp_up;
      dn_d = cmp_dn;
    end
  end

  assign ctl.throttle_up   = up_q;
  assign ctl.throttle_down = dn_q;
  assign ctl.cruise_active = active_q;
  assign ctl.target_speed  = target_q;

endmodule

// File: tb/tb_cruise_speed_controller.sv
// Directed table-driven bench for cruise_speed_controller plus an async-reset sequence.
module tb_cruise_speed_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cruise_speed_controller_if cif ();

  cruise_speed_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (cif)
  );

  typedef struct {
    logic       on, set, res, inc, dec, brk, sv;
    logic [7:0] spd;
    logic       up, dn, act;
    logic [7:0] tgt;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t v(input logic on, set, res, inc, dec, brk, sv,
                             input logic [7:0] spd,
                             input logic up, dn, act, input logic [7:0] tgt);
    vec_t r;
    r.on = on; r.set = set; r.res = res; r.inc = inc; r.dec = dec;
    r.brk = brk; r.sv = sv; r.spd = spd;
    r.up = up; r.dn = dn; r.act = act; r.tgt = tgt;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int idx,
                         input logic up, dn, act, input logic [7:0] tgt);
    chk({name, ".throttle_up"},   idx, {7'd0, cif.throttle_up},   {7'd0, up});
    chk({name, ".throttle_down"}, idx, {7'd0, cif.throttle_down}, {7'd0, dn});
    chk({name, ".cruise_active"}, idx, {7'd0, cif.cruise_active}, {7'd0, act});
    chk({name, ".target_speed"},  idx, cif.target_speed,          tgt);
  endtask

  task automatic drive(input vec_t r);
    cif.cruise_on = r.on; cif.set = r.set; cif.resume = r.res;
    cif.inc = r.inc; cif.dec = r.dec; cif.brake = r.brk;
    cif.speed_valid = r.sv; cif.speed = r.spd;
  endtask

  task automatic step(input vec_t r, input string name, input int idx);
    drive(r);
    @(posedge clk);
    #1;
    chk_all(name, idx, r.up, r.dn, r.act, r.tgt);
  endtask

  localparam logic HY =
`ifdef CRUISE_HYST_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    //           on set res inc dec brk sv spd    up dn act tgt
    vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 8'd0,   0, 0, 0, 8'd0));   // OFF -> READY
    vq.push_back(v(1, 1, 0, 0, 0, 0, 0, 8'd30,  0, 0, 0, 8'd0));   // out of range set
    vq.push_back(v(1, 1, 0, 0, 0, 0, 0, 8'd80,  0, 0, 1, 8'd80));  // engage
    vq.push_back(v(1, 0, 0, 0, 0, 0, 1, 8'd70,  1, 0, 1, 8'd80));
    vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 8'd0,   1, 0, 1, 8'd80));  // hold
    vq.push_back(v(1, 0, 0, 0, 0, 0, 1, 8'd90,  0, 1, 1, 8'd80));
    vq.push_back(v(1, 0, 0, 0, 0, 0, 1, 8'd80,  0, 0, 1, 8'd80));
    vq.push_back(v(1, 0, 0, 1, 0, 0, 1, 8'd70,  1, 0, 1, 8'd82));  // compares old target
    vq.push_back(v(1, 0, 0, 0, 0, 0, 1, 8'd82,  0, 0, 1, 8'd82));
    vq.push_back(v(1, 1, 0, 0, 0, 0, 0, 8'd199, 0, 0, 1, 8'd199)); // recapture
    vq.push_back(v(1, 0, 0, 1, 0, 0, 0, 8'd0,   0, 0, 1, 8'd200)); // sat at MAX
    vq.push_back(v(1, 0, 0, 1, 0, 0, 0, 8'd0,   0, 0, 1, 8'd200));
    vq.push_back(v(1, 1, 0, 0, 0, 0, 0, 8'd46,  0, 0, 1, 8'd46));
    vq.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'd0,   0, 0, 1, 8'd45));  // sat at MIN
    vq.push_back(v(1, 0, 0, 0, 1, 0, 0, 8'd0,   0, 0, 1, 8'd45));
    vq.push_back(v(1, 0, 0, 1, 1, 0, 0, 8'd0,   0, 0, 1, 8'd45));  // inc&dec
    vq.push_back(v(1, 1, 0, 0, 0, 0, 0, 8'd100, 0, 0, 1, 8'd100));
    vq.push_back(v(1, 0, 0, 0, 0, 0, 1, 8'd90,  1, 0, 1, 8'd100));
    vq.push_back(v(1, 0, 0, 0, 0, 1, 0, 8'd0,   0, 0, 0, 8'd100)); // brake -> SUSPEND
    vq.push_back(v(1, 0, 1, 0, 0, 1, 0, 8'd0,   0, 0, 0, 8'd100)); // resume ignored
    vq.push_back(v(1, 1, 0, 0, 0, 1, 0, 8'd120, 0, 0, 0, 8'd100)); // set ignored
    vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 8'd0,   0, 0, 0, 8'd100));
    vq.push_back(v(1, 0, 1, 0, 0, 0, 0, 8'd0,   0, 0, 1, 8'd100)); // resume
    vq.push_back(v(1, 0, 0, 0, 0, 0, 1, 8'd98,  !HY, 0, 1, 8'd100));
    vq.push_back(v(1, 0, 0, 0, 0, 0, 1, 8'd96,  1, 0, 1, 8'd100));
    vq.push_back(v(1, 0, 0, 0, 0, 0, 1, 8'd104, 0, 1, 1, 8'd100));
    vq.push_back(v(1, 1, 0, 0, 0, 0, 0, 8'd210, 0, 1, 1, 8'd100)); // bad set, hold
    vq.push_back(v(1, 0, 0, 0, 0, 0, 1, 8'd255, 0, 1, 1, 8'd100));
    vq.push_back(v(1, 0, 0, 0, 0, 1, 0, 8'd0,   0, 0, 0, 8'd100));
    vq.push_back(v(1, 1, 0, 0, 0, 0, 0, 8'd120, 0, 0, 1, 8'd120)); // SUSPEND set
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 8'd0,   0, 0, 0, 8'd0));   // switch off

    reset = 1'b1;
    drive(v(0, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 8'd0));
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 8'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_reset", 0, 0, 0, 0, 8'd0);

    foreach (vq[i]) step(vq[i], "vec", i);

    // Async reset mid-CRUISE with throttle_up high
    step(v(1, 0, 0, 0, 0, 0, 0, 8'd0,  0, 0, 0, 8'd0),  "ar_ready", 0);
    step(v(1, 1, 0, 0, 0, 0, 0, 8'd80, 0, 0, 1, 8'd80), "ar_set", 1);
    step(v(1, 0, 0, 0, 0, 0, 1, 8'd60, 1, 0, 1, 8'd80), "ar_up", 2);
    drive(v(1, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 8'd0));
    #2;
    reset = 1'b1;
    #1;
    chk_all("ar_async", 3, 0, 0, 0, 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all("ar_held", 4, 0, 0, 0, 8'd0);
    // OFF after release: a valid set one cycle later must not engage yet
    step(v(1, 1, 0, 0, 0, 0, 0, 8'd80, 0, 0, 0, 8'd0),  "ar_off", 5);
    step(v(1, 1, 0, 0, 0, 0, 0, 8'd80, 0, 0, 1, 8'd80), "ar_reengage", 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
